// File: rtl/memory_arbiter.sv
// Two-master to one-slave memory arbiter (instruction fetch = master 0, data = master 1).
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin conflicts; otherwise master 1 has fixed priority.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              m_req,
  input  logic [1:0]              m_we,
  input  logic [2*ADDR_WIDTH-1:0] m_addr,
  input  logic [2*DATA_WIDTH-1:0] m_wdata,
  output logic [1:0]              m_ack,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    s_req,
  output logic                    s_we,
  output logic [ADDR_WIDTH-1:0]   s_addr,
  output logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH-1:0]   s_rdata,
  input  logic                    s_ack,
  output logic [1:0]              grant,
  output logic [1:0]              fsm_state
);

  // Handshake: a master holds m_req (and its fields) until it sees its one-cycle m_ack;
  // s_req/s_we/s_addr/s_wdata stay stable from the grant until the cycle s_ack is sampled.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic                    win;
  logic                    s_req_next, s_we_next;
  logic [ADDR_WIDTH-1:0]   s_addr_next;
  logic [DATA_WIDTH-1:0]   s_wdata_next, m_rdata_next;
  logic [1:0]              m_ack_next, grant_next;

  assign fsm_state = state;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
  logic last, last_next;

  // On conflict the master that was not served last wins.
  always_comb begin
    win = m_req[1];
    if (m_req == 2'b11) win = ~last;
  end
`else
  // Fixed priority: master 1 wins whenever it requests.
  always_comb begin
    win = m_req[1];
  end
`endif

  always_comb begin
    state_next   = state;
    s_req_next   = s_req;
    s_we_next    = s_we;
    s_addr_next  = s_addr;
    s_wdata_next = s_wdata;
    m_rdata_next = m_rdata;
    grant_next   = grant;
    m_ack_next   = 2'b00;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    last_next    = last;
`endif
    case (state)
      IDLE: begin
        if (m_req != 2'b00) begin
          s_we_next    = m_we[win];
          s_addr_next  = win ? m_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : m_addr[ADDR_WIDTH-1:0];
          s_wdata_next = win ? m_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : m_wdata[DATA_WIDTH-1:0];
          grant_next   = win ? 2'b10 : 2'b01;
          s_req_next   = 1'b1;
          state_next   = ACCESS;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
          last_next    = win;
`endif
        end
      end
      ACCESS: begin
        if (s_ack) begin
          m_rdata_next = s_rdata;
          s_req_next   = 1'b0;
          m_ack_next   = grant;
          state_next   = DONE;
        end
      end
      DONE: begin
        grant_next = 2'b00;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      s_req   <= 1'b0;
      s_we    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      m_ack   <= 2'b00;
      m_rdata <= '0;
      grant   <= 2'b00;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last    <= 1'b1;
`endif
    end else begin
      state   <= state_next;
      s_req   <= s_req_next;
      s_we    <= s_we_next;
      s_addr  <= s_addr_next;
      s_wdata <= s_wdata_next;
      m_ack   <= m_ack_next;
      m_rdata <= m_rdata_next;
      grant   <= grant_next;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
      last    <= last_next;
`endif
    end
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: address width of every master and of the slave port.
REQ-002 Parameter DATA_WIDTH, default 32: data width of every master and of the slave port.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m_req  in  2  per-master request; bit0 = instruction fetch, bit1 = data port; held high until matching m_ack.
REQ-006 m_we  in  2  per-master write enable, sampled with m_req.
REQ-007 m_addr  in  2*ADDR_WIDTH  per-master address; master i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 m_wdata  in  2*DATA_WIDTH  per-master write data, same packing as m_addr.
REQ-009 m_ack  out  2  per-master one-cycle completion pulse.
REQ-010 m_rdata  out  DATA_WIDTH  registered read data, shared by both masters, valid in the m_ack cycle.
REQ-011 s_req  out  1  slave request, held high until s_ack.
REQ-012 s_we  out  1  slave write enable.
REQ-013 s_addr  out  ADDR_WIDTH  slave address.
REQ-014 s_wdata  out  DATA_WIDTH  slave write data.
REQ-015 s_rdata  in  DATA_WIDTH  slave read data, valid with s_ack.
REQ-016 s_ack  in  1  slave completion, one or more cycles after s_req rises.
REQ-017 grant  out  2  one-hot current owner; 2'b00 when no transaction in flight.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; encoding is free.
REQ-019 IDLE: if m_req != 0, winner selected per REQ-027/028; winner's we/addr/wdata latched into s_we/s_addr/s_wdata; grant set; s_req=1; next ACCESS. If m_req == 0, stay IDLE.
REQ-020 ACCESS: s_req and latched fields held stable; on s_ack: s_rdata captured into m_rdata, s_req=0, m_ack[owner]=1 for exactly one cycle, next DONE.
REQ-021 DONE: m_ack returns to 0, grant=0, m_req ignored, next IDLE (one bubble cycle so masters can drop req).
REQ-022 Latency: m_req high in cycle 0 -> s_req high cycle 1; s_ack in cycle k -> m_ack high cycle k+1; zero-wait slave (s_ack in cycle 1) gives m_ack in cycle 2.
REQ-023 s_ack while IDLE or DONE ignored; no m_ack, no m_rdata update.
REQ-024 Master dropping m_req during ACCESS: transaction still completes and m_ack still pulses for it.
REQ-025 Master still requesting in IDLE after DONE: starts a new transaction (back-to-back period 3 cycles with zero-wait slave).
REQ-026 m_rdata updated only on captured s_ack; writes also update it with s_rdata (content don't-care to masters).
REQ-027 Arbitration when only one bit of m_req set: that master wins.
REQ-028 Arbitration when both set: per Configuration (REQ-032/033).

Reset
REQ-029 reset high at a rising edge: state=IDLE, s_req=0, s_we=0, s_addr=0, s_wdata=0, m_ack=0, m_rdata=0, grant=0, round-robin pointer = last-served master 1; reset overrides all other inputs.
REQ-030 Reset during ACCESS abandons the transaction: s_req low after that edge, no m_ack ever issued for it.

Configuration
REQ-031 Macro MEMORY_ARBITER_ROUND_ROBIN_EN selects conflict policy.
REQ-032 Defined: a 1-bit last-served pointer updates at each IDLE grant; on conflict the master not last served wins; after reset master 0 wins the first conflict.
REQ-033 Undefined: fixed priority, master 1 (data) always wins conflicts; no pointer state present.

Verification
REQ-034 Single read: m_req=2'b01, addr 0x40, slave s_ack one cycle after s_req with s_rdata=0xDEADBEEF -> s_addr=0x40, s_we=0, m_ack=2'b01 one cycle, m_rdata=0xDEADBEEF, grant 01 then 00.
REQ-035 Write with 3 slave wait cycles: m_req=2'b10, we=1, addr 0x100, wdata 0x12345678 -> s_req held 4 cycles with stable fields, m_ack=2'b10 the cycle after s_ack.
REQ-036 Conflict, both held continuously for 4 transactions: ROUND_ROBIN_EN defined -> grant order 01,10,01,10; undefined -> 10 repeatedly, master 0 starved.
REQ-037 Reset in ACCESS: reset pulsed before s_ack -> next cycle s_req=0, grant=0, m_ack never asserted; later s_ack ignored.
REQ-038 Spurious s_ack in IDLE with m_req=0 -> m_ack stays 0, m_rdata unchanged.
